// File: rtl/arcade_input_conditioner_if.sv
// Player-input bus between the DB9 pins / keyboard translator and the game core.
// The master drives the raw inputs; the slave (the conditioner) drives the button outputs.
interface arcade_input_conditioner_if;
    logic [5:0] joy1_n;     // {p9, p6, right, left, down, up}, active-low, asynchronous
    logic [8:0] kbd_joy;    // keyboard vector joyBCPPFRLDU, active-high, clk domain
    logic [7:0] buttons_n;  // {right, left, start1, start2, fire, coin, thrust, shield}, active-low
    logic [5:0] joy_db;     // debounced joystick, active-high

    modport master (output joy1_n, output kbd_joy, input  buttons_n, input  joy_db);
    modport slave  (input  joy1_n, input  kbd_joy, output buttons_n, output joy_db);
endinterface

// File: rtl/arcade_input_conditioner.sv
// Synchronises and debounces joystick-1, stretches the coin key and merges
// everything with the keyboard vector into one registered active-low button bus.
module arcade_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CW              = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stb
);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stb <= 1'b1;
            cnt <= '0;
        end else if (din == stb) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            stb <= din;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module arcade_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int COIN_CYCLES     = 1250000
) (
    input  logic                       clk,
    input  logic                       reset,
    arcade_input_conditioner_if.slave  io
);
    localparam int              CTW       = $clog2(COIN_CYCLES + 1);
    localparam logic [CTW-1:0]  COIN_LOAD = CTW'(COIN_CYCLES);

    logic [5:0]     joy_s1, joy_s2, stb;
    logic           coin_prev, coin_rise, coin_act;
    logic [CTW-1:0] coin_tmr;
    logic           thrust, fire, shield, left_raw, right_raw, left, right;
    logic           unused_kbd_down;

    // Two-flop synchroniser; released (1) out of reset so nothing fires spuriously.
    always_ff @(posedge clk) begin
        if (reset) begin
            joy_s1 <= 6'h3F;
            joy_s2 <= 6'h3F;
        end else begin
            joy_s1 <= io.joy1_n;
            joy_s2 <= joy_s1;
        end
    end

    arcade_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [5:0] (
        .clk   (clk),
        .reset (reset),
        .din   (joy_s2),
        .stb   (stb)
    );

    assign io.joy_db = ~stb;

    // coin_prev resets high so a key held through reset never counts as a rise.
    assign coin_rise = io.kbd_joy[7] & ~coin_prev;
    assign coin_act  = (coin_tmr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            coin_prev <= 1'b1;
            coin_tmr  <= '0;
        end else begin
            coin_prev <= io.kbd_joy[7];
            if (coin_act)
                coin_tmr <= coin_tmr - 1'b1;
            else if (coin_rise)
                coin_tmr <= COIN_LOAD;
        end
    end

    assign thrust    = io.kbd_joy[0] | io.joy_db[0];
    assign left_raw  = io.kbd_joy[2] | io.joy_db[2];
    assign right_raw = io.kbd_joy[3] | io.joy_db[3];
    assign fire      = io.kbd_joy[4] | io.joy_db[4];
    assign shield    = io.kbd_joy[8] | io.joy_db[5];

    // Opposing rotation requests cancel rather than letting one side win.
    assign left  = left_raw  & ~right_raw;
    assign right = right_raw & ~left_raw;

    // Down has no function in this core.
    assign unused_kbd_down = io.kbd_joy[1];

    always_ff @(posedge clk) begin
        if (reset)
            io.buttons_n <= 8'hFF;
        else
            io.buttons_n <= ~{right, left, io.kbd_joy[5], io.kbd_joy[6],
                              fire, coin_act, thrust, shield};
    end
endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Directed vectors with hand-computed expectations; a monitor checks one queued
// expectation after every clock edge.
module tb_arcade_input_conditioner;
    logic clk = 1'b0;
    logic reset;

    arcade_input_conditioner_if bus();

    arcade_input_conditioner #(.DEBOUNCE_CYCLES(4), .COIN_CYCLES(6)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] btn;
        logic [5:0] jdb;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: after each edge, compare outputs against the expectation queued for it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (bus.buttons_n !== e.btn) begin
                bad++;
                $display("FAIL %s buttons_n got=%h want=%h t=%0t", e.name, bus.buttons_n, e.btn, $time);
            end
            total++;
            if (bus.joy_db !== e.jdb) begin
                bad++;
                $display("FAIL %s joy_db got=%h want=%h t=%0t", e.name, bus.joy_db, e.jdb, $time);
            end
        end
    end

    // Drive inputs sampled at the next edge and queue the outputs expected after it.
    task automatic stepn(input int n, input logic rst, input logic [5:0] jn, input logic [8:0] kb,
                         input logic [7:0] eb, input logic [5:0] ej, input string nm);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            @(negedge clk);
            reset       = rst;
            bus.joy1_n  = jn;
            bus.kbd_joy = kb;
            e.btn  = eb;
            e.jdb  = ej;
            e.name = nm;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.joy1_n  = 6'h00;
        bus.kbd_joy = 9'h1FF;

        // Reset with every input active, then coin held through release: no pulse.
        stepn(3, 1, 6'h00, 9'h1FF, 8'hFF, 6'h00, "reset_all_active");
        stepn(8, 0, 6'h3F, 9'h080, 8'hFF, 6'h00, "coin_held_thru_reset");
        stepn(2, 0, 6'h3F, 9'h000, 8'hFF, 6'h00, "idle");

        // p6 glitch of 3 cycles is rejected.
        stepn(3, 0, 6'h2F, 9'h000, 8'hFF, 6'h00, "glitch_low");
        stepn(5, 0, 6'h3F, 9'h000, 8'hFF, 6'h00, "glitch_high");
        // Held press: joy_db after 6 edges, buttons one edge later.
        stepn(5, 0, 6'h2F, 9'h000, 8'hFF, 6'h00, "press_wait");
        stepn(1, 0, 6'h2F, 9'h000, 8'hFF, 6'h10, "press_joy_db");
        stepn(2, 0, 6'h2F, 9'h000, 8'hF7, 6'h10, "press_fire");
        // Release is debounced the same way.
        stepn(5, 0, 6'h3F, 9'h000, 8'hF7, 6'h10, "release_wait");
        stepn(1, 0, 6'h3F, 9'h000, 8'hF7, 6'h00, "release_joy_db");
        stepn(1, 0, 6'h3F, 9'h000, 8'hFF, 6'h00, "release_fire");

        // Coin held 20 cycles: exactly 6 cycles low, starting one cycle after the rise.
        stepn(1,  0, 6'h3F, 9'h080, 8'hFF, 6'h00, "coin_rise");
        stepn(6,  0, 6'h3F, 9'h080, 8'hFB, 6'h00, "coin_pulse");
        stepn(13, 0, 6'h3F, 9'h080, 8'hFF, 6'h00, "coin_held_after");
        stepn(3,  0, 6'h3F, 9'h000, 8'hFF, 6'h00, "coin_released");
        // Second rise inside the pulse does not extend it.
        stepn(1, 0, 6'h3F, 9'h080, 8'hFF, 6'h00, "coin2_rise");
        stepn(1, 0, 6'h3F, 9'h000, 8'hFB, 6'h00, "coin2_drop");
        stepn(5, 0, 6'h3F, 9'h080, 8'hFB, 6'h00, "coin2_rerise");
        stepn(5, 0, 6'h3F, 9'h080, 8'hFF, 6'h00, "coin2_no_extend");
        stepn(2, 0, 6'h3F, 9'h000, 8'hFF, 6'h00, "coin2_released");

        // Keyboard left plus debounced joystick right cancel each other.
        stepn(5, 0, 6'h37, 9'h004, 8'hBF, 6'h00, "rot_kbd_left");
        stepn(1, 0, 6'h37, 9'h004, 8'hBF, 6'h08, "rot_joy_right_db");
        stepn(2, 0, 6'h37, 9'h004, 8'hFF, 6'h08, "rot_cancel");
        stepn(1, 0, 6'h37, 9'h000, 8'h7F, 6'h08, "rot_right_only");
        stepn(5, 0, 6'h3F, 9'h000, 8'h7F, 6'h08, "rot_pin_release_wait");
        stepn(1, 0, 6'h3F, 9'h000, 8'h7F, 6'h00, "rot_pin_release_db");
        stepn(1, 0, 6'h3F, 9'h000, 8'hFF, 6'h00, "rot_idle");

        // One-cycle start1 pulse, down ignored, thrust+shield from keyboard.
        stepn(1, 0, 6'h3F, 9'h020, 8'hDF, 6'h00, "start1_pulse");
        stepn(1, 0, 6'h3F, 9'h000, 8'hFF, 6'h00, "start1_off");
        stepn(1, 0, 6'h3F, 9'h002, 8'hFF, 6'h00, "down_on");
        stepn(1, 0, 6'h3F, 9'h000, 8'hFF, 6'h00, "down_off");
        stepn(1, 0, 6'h3F, 9'h002, 8'hFF, 6'h00, "down_on2");
        stepn(1, 0, 6'h3F, 9'h101, 8'hFC, 6'h00, "thrust_shield");
        stepn(1, 0, 6'h3F, 9'h040, 8'hEF, 6'h00, "start2");
        stepn(1, 0, 6'h3F, 9'h000, 8'hFF, 6'h00, "merge_idle");

        // Reset three cycles into a coin pulse truncates it; held key does not re-fire.
        stepn(1, 0, 6'h3F, 9'h080, 8'hFF, 6'h00, "rst_coin_rise");
        stepn(2, 0, 6'h3F, 9'h080, 8'hFB, 6'h00, "rst_coin_pulse");
        stepn(2, 1, 6'h3F, 9'h080, 8'hFF, 6'h00, "rst_mid_pulse");
        stepn(7, 0, 6'h3F, 9'h080, 8'hFF, 6'h00, "rst_key_still_held");
        stepn(2, 0, 6'h3F, 9'h000, 8'hFF, 6'h00, "rst_key_released");

        // Let the monitor drain; an undrained queue counts as a failure.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
